// File: rtl/gray_codec_pipe_if.sv
// gray_codec_pipe_if
//   Handshake bundle for gray_codec_pipe.
//   Input side:  inStrobe, inMode, dataIn (to the block), inReady (from the block).
//   Output side: outStrobe, outMode, dataOut (from the block), outReady (to the block).
//
// Valid/ready: a word moves across a side on a rising clock edge where the
// strobe and the ready of that side are both high. While a strobe is high
// and no transfer has happened, the word it qualifies stays stable. A ready
// may depend combinationally on the opposite side's ready. It never depends
// on the strobe of its own side.
`timescale 1ns/1ps
interface gray_codec_pipe_if #(
  parameter int WIDTH = 32
);
  logic             inStrobe;
  logic             inReady;
  logic             inMode;
  logic [WIDTH-1:0] dataIn;
  logic             outStrobe;
  logic             outReady;
  logic             outMode;
  logic [WIDTH-1:0] dataOut;

  // Producer / consumer side (stimulus source and sink).
  modport master (
    output inStrobe, inMode, dataIn, outReady,
    input  inReady, outStrobe, outMode, dataOut
  );

  // Converter side.
  modport slave (
    input  inStrobe, inMode, dataIn, outReady,
    output inReady, outStrobe, outMode, dataOut
  );
endinterface

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe
//   Pipelined Gray-code converter. Each word carries a mode bit:
//   0 = Gray->binary decode, 1 = binary->Gray encode. Decode is split across
//   STAGES register stages. Each stage resolves one slice of the XOR prefix
//   chain, working from the MSB down. Encode is done entirely in stage 1 and
//   is passed through by the later stages, so both modes see the same latency.
//   Stages collapse bubbles, so the block sustains one word per clock.
// Ports:
//   clk   - rising-edge clock
//   rstN  - synchronous active-low reset; clears all stage valids and data
//   bus   - gray_codec_pipe_if.slave (inStrobe/inReady/inMode/dataIn,
//           outStrobe/outReady/outMode/dataOut)
`timescale 1ns/1ps
module gray_codec_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rstN,
  gray_codec_pipe_if.slave bus
);

  // Number of decode bits resolved per stage, rounded up.
  localparam int SLICE = (WIDTH + STAGES - 1) / STAGES;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] mode_q,  mode_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];

  logic [STAGES-1:0] accept;
  logic              in_ready;

  // Contents offered to each stage: the input port for stage 0, and the
  // previous register otherwise.
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_mode;
  logic [WIDTH-1:0]  src_data [STAGES];

  // Resolve the decode slice that belongs to stage k (0-based). Bits above
  // the slice are already binary, so walking downward lets each bit use the
  // resolved bit directly above it. The MSB is its own binary value.
  function automatic logic [WIDTH-1:0] resolve_slice(input logic [WIDTH-1:0] w,
                                                     input int k);
    logic [WIDTH-1:0] r;
    int hi;
    int lo;
    r  = w;
    hi = WIDTH - 1 - k * SLICE;
    lo = WIDTH - (k + 1) * SLICE;
    if (lo < 0) lo = 0;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (i <= hi && i >= lo) r[i] = r[i+1] ^ r[i];
    end
    return r;
  endfunction

  // Stage k can take new contents when it or any stage after it is empty,
  // or when the sink is ready. This is the unrolled form of
  // "empty or next stage accepts".
  always_comb begin
    accept = '0;
    for (int k = 0; k < STAGES; k++) begin
      accept[k] = bus.outReady;
      for (int j = 0; j < STAGES; j++) begin
        if (j >= k && !valid_q[j]) accept[k] = 1'b1;
      end
    end
  end

  assign in_ready    = accept[0] && rstN;
  assign bus.inReady = in_ready;

  always_comb begin
    src_valid = '0;
    src_mode  = '0;
    for (int k = 0; k < STAGES; k++) src_data[k] = '0;
    src_valid[0] = bus.inStrobe && in_ready;
    src_mode[0]  = bus.inMode;
    src_data[0]  = bus.dataIn;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_data[k]  = data_q[k-1];
    end
  end

  // An accepting stage takes its source valid. A bubble in that slot empties
  // the stage. Mode and data load only when a real word arrives.
  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    data_d  = data_q;
    for (int k = 0; k < STAGES; k++) begin
      if (accept[k]) begin
        valid_d[k] = src_valid[k];
        if (src_valid[k]) begin
          mode_d[k] = src_mode[k];
          if (src_mode[k]) begin
            data_d[k] = (k == 0) ? (src_data[k] ^ (src_data[k] >> 1)) : src_data[k];
          end else begin
            data_d[k] = resolve_slice(src_data[k], k);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      valid_q <= '0;
      mode_q  <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

  assign bus.outStrobe = valid_q[STAGES-1];
  assign bus.outMode   = mode_q[STAGES-1];
  assign bus.dataOut   = data_q[STAGES-1];

endmodule

// File: tb/tb_gray_codec_pipe.sv
`timescale 1ns/1ps
module tb_gray_codec_pipe;
  localparam int W = 32;
  localparam int S = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  gray_codec_pipe_if #(.WIDTH(W)) bus ();
  gray_codec_pipe #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rstN(rstN), .bus(bus));

  gray_codec_pipe_if #(.WIDTH(3)) c1_if ();
  gray_codec_pipe_if #(.WIDTH(3)) c2_if ();
  gray_codec_pipe_if #(.WIDTH(3)) c3_if ();
  gray_codec_pipe #(.WIDTH(3), .STAGES(1)) u_c1 (.clk(clk), .rstN(rstN), .bus(c1_if));
  gray_codec_pipe #(.WIDTH(3), .STAGES(2)) u_c2 (.clk(clk), .rstN(rstN), .bus(c2_if));
  gray_codec_pipe #(.WIDTH(3), .STAGES(3)) u_c3 (.clk(clk), .rstN(rstN), .bus(c3_if));

  logic [2:0] c_ostr;
  logic [2:0] c_omode;
  logic [2:0] c_odat [3];
  assign c_ostr    = {c3_if.outStrobe, c2_if.outStrobe, c1_if.outStrobe};
  assign c_omode   = {c3_if.outMode, c2_if.outMode, c1_if.outMode};
  assign c_odat[0] = c1_if.dataOut;
  assign c_odat[1] = c2_if.dataOut;
  assign c_odat[2] = c3_if.dataOut;

  // Hand-computed 3-bit tables: Gray->binary and binary->Gray.
  localparam logic [2:0] DEC3 [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd7, 3'd6, 3'd4, 3'd5};
  localparam logic [2:0] ENC3 [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [W-1:0] data;
    logic         mode;
    bit           lat;
    int           cyc;
  } exp_t;
  logic [W-1:0] exp_q [$];  // expected data, in order
  exp_t         meta_q [$]; // mode / latency info paired with exp_q

  typedef struct {
    logic [8*16-1:0] name;
    logic [63:0]     got;
    logic [63:0]     exp;
  } chk_t;
  chk_t chk_q [$];

  logic [2:0] cq_data [64];
  logic       cq_mode [64];
  int         cq_cyc  [64];
  int         cn = 0;
  int         cp [3] = '{0, 0, 0};

  int checks   = 0;
  int failures = 0;

  int bp_mode = 0; // 0: outReady high, 1: outReady low, 2: random

  // ---------------- models ----------------
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic post(input logic [8*16-1:0] nm, input logic [63:0] g, input logic [63:0] e);
    chk_t c;
    c.name = nm; c.got = g; c.exp = e;
    chk_q.push_back(c);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic m, input logic [W-1:0] d, input logic [W-1:0] e,
                      input bit lat, output int waits);
    int   n;
    bit   ok;
    exp_t x;
    n = 0;
    bus.inStrobe = 1'b1;
    bus.inMode   = m;
    bus.dataIn   = d;
    do begin
      @(negedge clk);
      ok = bus.inReady;
      if (ok) begin
        x.data = e; x.mode = m; x.lat = lat; x.cyc = cyc + S;
        exp_q.push_back(e);
        meta_q.push_back(x);
      end else begin
        n++;
      end
      @(posedge clk); #1;
    end while (!ok && n < 500);
    if (!ok) post("send_timeout", 64'd1, 64'd0);
    bus.inStrobe = 1'b0;
    waits = n;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) post("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic csend(input logic m, input logic [2:0] d, input logic [2:0] e);
    c1_if.inStrobe = 1'b1; c2_if.inStrobe = 1'b1; c3_if.inStrobe = 1'b1;
    c1_if.inMode = m; c2_if.inMode = m; c3_if.inMode = m;
    c1_if.dataIn = d; c2_if.dataIn = d; c3_if.dataIn = d;
    @(negedge clk);
    post("c_inready", 64'({c3_if.inReady, c2_if.inReady, c1_if.inReady}), 64'd7);
    cq_data[cn] = e;
    cq_mode[cn] = m;
    cq_cyc[cn]  = cyc;
    cn++;
    @(posedge clk); #1;
    c1_if.inStrobe = 1'b0; c2_if.inStrobe = 1'b0; c3_if.inStrobe = 1'b0;
  endtask

  // ---------------- sink ready generator ----------------
  initial begin
    bus.outReady = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (bp_mode)
        0:       bus.outReady = 1'b1;
        1:       bus.outReady = 1'b0;
        default: bus.outReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic cmp(input logic [8*16-1:0] nm, input logic [63:0] g, input logic [63:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %0s got=%0h exp=%0h (t=%0t)", nm, g, e, $time);
    end
  endtask

  bit           stall_prev = 1'b0;
  logic [W-1:0] held_d;
  logic         held_m;

  always @(negedge clk) begin
    logic [W-1:0] e;
    exp_t         x;
    chk_t         c;
    int           idx;
    if (rstN) begin
      if (stall_prev) begin
        cmp("hold_strobe", 64'(bus.outStrobe), 64'd1);
        cmp("hold_data", 64'(bus.dataOut), 64'(held_d));
        cmp("hold_mode", 64'(bus.outMode), 64'(held_m));
      end
      if (bus.outStrobe && bus.outReady) begin
        if (exp_q.size() == 0) begin
          cmp("unexpected_out", 64'(bus.dataOut), 64'hDEAD_0000_0000_0000);
        end else begin
          e = exp_q.pop_front();
          x = meta_q.pop_front();
          cmp("out_data", 64'(bus.dataOut), 64'(e));
          cmp("out_mode", 64'(bus.outMode), 64'(x.mode));
          if (x.lat) cmp("latency", 64'(cyc), 64'(x.cyc));
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (c_ostr[k]) begin
          if (cp[k] >= cn) begin
            cmp("c_unexpected", 64'(k), 64'hDEAD);
          end else begin
            idx = cp[k];
            cmp("c_data", 64'(c_odat[k]), 64'(cq_data[idx]));
            cmp("c_mode", 64'(c_omode[k]), 64'(cq_mode[idx]));
            cmp("c_latency", 64'(cyc), 64'(cq_cyc[idx] + k + 1));
            cp[k] = cp[k] + 1;
          end
        end
      end
    end
    stall_prev = rstN && bus.outStrobe && !bus.outReady;
    held_d     = bus.dataOut;
    held_m     = bus.outMode;
    while (chk_q.size() != 0) begin
      c = chk_q.pop_front();
      cmp(c.name, c.got, c.exp);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int stall_cnt;
    int acc;
    logic [W-1:0] d;
    logic m;
    exp_t x;

    bus.inStrobe = 1'b0; bus.inMode = 1'b0; bus.dataIn = '0;
    c1_if.inStrobe = 1'b0; c1_if.inMode = 1'b0; c1_if.dataIn = '0; c1_if.outReady = 1'b1;
    c2_if.inStrobe = 1'b0; c2_if.inMode = 1'b0; c2_if.dataIn = '0; c2_if.outReady = 1'b1;
    c3_if.inStrobe = 1'b0; c3_if.inMode = 1'b0; c3_if.dataIn = '0; c3_if.outReady = 1'b1;
    rstN = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    post("rst_outstrobe", 64'(bus.outStrobe), 64'd0);
    post("rst_dataout", 64'(bus.dataOut), 64'd0);
    post("rst_outmode", 64'(bus.outMode), 64'd0);
    post("rst_inready", 64'(bus.inReady), 64'd0);
    post("rst_c_strobe", 64'(c_ostr), 64'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    post("rel_inready", 64'(bus.inReady), 64'd1);
    @(posedge clk); #1;

    // Directed decode / encode, latency-checked
    send(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, w);
    send(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, w);
    drain();
    send(1'b1, 32'h0000_000B, 32'h0000_000E, 1'b1, w);
    send(1'b0, 32'h0000_000E, 32'h0000_000B, 1'b1, w);
    send(1'b0, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 1'b1, w);
    send(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, w);
    send(1'b1, 32'h8000_0000, 32'hC000_0000, 1'b1, w);
    send(1'b0, 32'h0000_0001, 32'h0000_0001, 1'b1, w);
    drain();

    // Back-to-back stream of Gray(n)
    stall_cnt = 0;
    for (int n = 0; n < 1024; n++) begin
      d = W'(n);
      send(1'b0, b2g(d), d, 1'b1, w);
      stall_cnt += w;
    end
    post("stream_stalls", 64'(stall_cnt), 64'd0);
    drain();

    // Full stall: exactly S words fit, then inReady drops
    bp_mode = 1;
    @(posedge clk); #3;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      d = W'(100 + acc);
      bus.inStrobe = 1'b1; bus.inMode = 1'b0; bus.dataIn = b2g(d);
      @(negedge clk);
      if (bus.inReady) begin
        x.data = d; x.mode = 1'b0; x.lat = 1'b0; x.cyc = 0;
        exp_q.push_back(d);
        meta_q.push_back(x);
        acc++;
      end
      @(posedge clk); #1;
    end
    bus.inStrobe = 1'b0;
    @(negedge clk);
    post("bp_inready", 64'(bus.inReady), 64'd0);
    post("bp_accepted", 64'(acc), 64'(S));
    post("bp_strobe", 64'(bus.outStrobe), 64'd1);
    @(posedge clk); #1;
    bp_mode = 0;
    drain();

    // Random backpressure, mixed modes, against the bit-serial model
    bp_mode = 2;
    for (int n = 0; n < 1000; n++) begin
      d = {$urandom, $urandom} >> (64 - W);
      m = 1'($urandom_range(0, 1));
      send(m, d, m ? b2g(d) : g2b(d), 1'b0, w);
    end
    bp_mode = 0;
    drain();

    // Reset with three words in flight
    send(1'b0, 32'h0000_0003, 32'h0000_0002, 1'b0, w);
    send(1'b0, 32'h0000_0007, 32'h0000_0005, 1'b0, w);
    send(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, w);
    exp_q.delete();
    meta_q.delete();
    rstN = 1'b0;
    @(negedge clk);
    post("mid_rst_inready", 64'(bus.inReady), 64'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    post("mid_rst_strobe", 64'(bus.outStrobe), 64'd0);
    post("mid_rst_data", 64'(bus.dataOut), 64'd0);
    post("mid_rst_inrdy_hi", 64'(bus.inReady), 64'd1);
    @(posedge clk); #1;
    send(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, w);
    drain();
    repeat (6) @(posedge clk);
    #1;

    // WIDTH = 3 corner instances, STAGES = 1, 2, 3
    for (int v = 0; v < 8; v++) csend(1'b0, 3'(v), DEC3[v]);
    for (int v = 0; v < 8; v++) csend(1'b1, 3'(v), ENC3[v]);
    repeat (6) @(posedge clk);
    @(negedge clk);
    post("c1_count", 64'(cp[0]), 64'd16);
    post("c2_count", 64'(cp[1]), 64'd16);
    post("c3_count", 64'(cp[2]), 64'd16);

    // Flush posted checks, then report
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_codec_pipe.md
# gray_codec_pipe

Pipelined, parametrised Gray-code converter for the decoders library: the next generation of the single-width Gray-to-binary block. Each word carries a mode bit selecting Gray→binary decode or binary→Gray encode. The decode XOR prefix chain is split across a configurable number of register stages to meet timing at wide WIDTH. Input and output use valid/ready handshakes with bubble-collapsing stages, so the block sustains one word per clock under backpressure.

## Interface

- WIDTH, 32, data width in bits; legal range 2..64.
- STAGES, 4, number of pipeline register stages; legal range 1..WIDTH.

- clk  input  1  system clock; all logic on the rising edge.
- rstN  input  1  system reset; synchronous, active-low.
- inStrobe  input  1  input word valid.
- inReady  output  1  block can accept a word this cycle.
- inMode  input  1  0 = decode Gray→binary, 1 = encode binary→Gray.
- dataIn  input  WIDTH  input word.
- outStrobe  output  1  dataOut/outMode valid.
- outReady  input  1  downstream accepts the word this cycle.
- outMode  output  1  mode of the word on dataOut.
- dataOut  output  WIDTH  converted word.

## Operation

- Transfer in: inStrobe && inReady at a rising edge. Transfer out: outStrobe && outReady at a rising edge.
- Pipeline is STAGES registers, each holding {valid, mode, partial word}. The last stage drives outStrobe/outMode/dataOut.
- Stage k (1..STAGES) accepts new contents when it is empty or stage k+1 accepts (for the last stage: when outReady is high). inReady = stage-1 accept condition && rstN. A word leaves a stage only when the next stage accepts it, so bubbles collapse.
- Decode: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i]. With S = ceil(WIDTH/STAGES), stage k resolves bits WIDTH-1-(k-1)·S down to max(0, WIDTH-k·S) from the MSB side, using the resolved bit immediately above the slice. Unresolved bits pass through unchanged. Stages whose slice is empty pass data through.
- Encode: g = b ^ (b >> 1), computed entirely in stage 1. Later stages pass it through, so both modes have identical latency and words never reorder.
- Mode travels with its word. Mixed-mode streams are legal with no penalty.
- Pure bit-level logic. No arithmetic carries. Output width equals input width, and no bits are masked.

## Timing

- Reset (rstN low at a rising edge): all stage valids clear. outStrobe = 0, outMode = 0, dataOut = 0 after that edge. inReady = 0 while rstN is low.
- Reset mid-operation: all in-flight words are discarded with no partial output. inReady returns high in the first cycle with rstN high.
- Latency: a word accepted at edge t is on dataOut with outStrobe high after edge t+STAGES-1 when there is no backpressure. For STAGES = 1, it is valid the cycle after acceptance.
- Throughput: one word per clock with outReady held high.
- While outStrobe && !outReady, dataOut and outMode hold stable. Upstream stages keep filling until full. After that, inReady = 0. Inputs are ignored when inReady = 0.
- Capacity under full stall: exactly STAGES words.
- Simultaneous out-transfer and in-transfer in a full pipeline: both occur in the same cycle. Occupancy is unchanged, and inReady stays high combinationally through outReady.
- Stall and release do not lose or duplicate words.

## Test plan

- Decode with WIDTH = 32, STAGES = 4, outReady = 1: inMode = 0, dataIn = 0x80000000. Required: dataOut = 0xFFFFFFFF and outMode = 0, valid exactly after edge t+3. dataIn = 0x00000000 → 0x00000000.
- Encode: inMode = 1, dataIn = 0x0000000B. Required: dataOut = 0x0000000E at the same 4-edge latency. Interleaving decode of 0x0000000E on the next cycle returns 0x0000000B in order, one cycle later.
- Stream: 1024 back-to-back words, Gray(n) for n = 0..1023, decode mode, outReady = 1. Required: outputs 0..1023 on consecutive cycles, outStrobe continuously high after fill, inReady always high.
- Backpressure: streaming decode with outReady forced low for 10 cycles. Required: exactly 4 words accepted before inReady drops and dataOut holds. After release, all words emerge in order with no loss or duplicate. Random outReady toggling over 1000 words gives no mismatches against a bit-serial model.
- Reset mid-stream: rstN low for 1 edge with 3 words in flight. Required: outStrobe = 0 and dataOut = 0 after that edge, those 3 words never emerge, and the next accepted word converts correctly.
- Corner parameters: WIDTH = 3 with STAGES = 1, 2 and 3. Exhaustively decode all 8 codes (e.g. 3'b100 → 3'b111, 3'b110 → 3'b100) and encode all 8 values. Required: matches the reference model with latency = STAGES.
